// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the dmem arbiter: port ids, lock-state
// encoding, read-return tag layout and the starvation-counter step function.
package dmem_arbiter_pkg;

   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 32;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   typedef struct packed {
      logic valid;
      logic owner;
   } rtag_t;

   // The counter only measures an unbroken run of CPU wins while AUX waits.
   function automatic logic [3:0] starve_next(
      input logic [3:0] cnt,
      input logic [3:0] lim,
      input logic       aux_req,
      input logic       cpu_gnt,
      input logic       aux_gnt
   );
      if (!aux_req || aux_gnt) return 4'd0;
      if (cpu_gnt && (cnt < lim)) return cnt + 4'd1;
      return cnt;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle and dmem pin bundle used by dmem_arbiter.
// master = the side that initiates (requester / arbiter toward memory).
interface dmem_port_if
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface dmem_mem_if
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              wren;
   logic [DATA_W-1:0] q;

   modport master (output addr, data, wren, input q);
   modport slave  (input addr, data, wren, output q);
endinterface

// File: rtl/dmem_rtag_pipe.sv
// Read-return tag delay line: a {valid, owner} tag enters on every edge and
// leaves DEPTH edges later, lined up with the dmem read latency.
module dmem_rtag_pipe
   import dmem_arbiter_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic  clock,
   input  logic  reset,
   input  rtag_t tag_in,
   output rtag_t tag_out
);
   rtag_t stage_q [DEPTH];
   rtag_t stage_d [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            always_comb stage_d[gi] = tag_in;
         end else begin : g_body
            always_comb stage_d[gi] = stage_q[gi-1];
         end

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) stage_q[gi] <= '0;
            else        stage_q[gi] <= stage_d[gi];
         end
      end
   endgenerate

   assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port dmem: CPU port has fixed priority,
// a starvation counter and a burst lock serve the AUX port, reads return by tag.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int READ_LAT   = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic       clock,
   input  logic       reset,
   dmem_port_if.slave p0,
   dmem_port_if.slave p1,
   input  logic       lock1,
   dmem_mem_if.master mem
);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   lock_state_t       lock_state_q, lock_state_d;
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic              gnt0, gnt1;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] wdata_sel;
   logic              wren_sel;
   rtag_t             tag_in, tag_out;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   // reset is active low, so grants are only issued while it is high
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset) begin
         if ((lock_state_q == LOCKED) && p1.req)          gnt1 = 1'b1;
         else if (p1.req && (starve_cnt_q == STARVE_LIM)) gnt1 = 1'b1;
         else if (p0.req)                                 gnt0 = 1'b1;
         else if (p1.req)                                 gnt1 = 1'b1;
      end
   end

   always_comb begin
      addr_sel  = p0.addr;
      wdata_sel = p0.wdata;
      wren_sel  = 1'b0;
      if (gnt1) begin
         addr_sel  = p1.addr;
         wdata_sel = p1.wdata;
         wren_sel  = p1.we;
      end else if (gnt0) begin
         wren_sel  = p0.we;
      end
   end

   assign mem.addr  = addr_sel;
   assign mem.data  = wdata_sel;
   assign mem.wren  = wren_sel;
   assign p0.gnt    = gnt0;
   assign p1.gnt    = gnt1;
   assign p0.rvalid = rvalid0_q;
   assign p1.rvalid = rvalid1_q;
   assign p0.rdata  = rdata0_q;
   assign p1.rdata  = rdata1_q;

   always_comb begin
      tag_in       = '0;
      tag_in.valid = (gnt0 && !p0.we) || (gnt1 && !p1.we);
      tag_in.owner = gnt1 ? PORT_AUX : PORT_CPU;
   end

   dmem_rtag_pipe #(
      .DEPTH (READ_LAT)
   ) u_rtag_pipe (
      .clock   (clock),
      .reset   (reset),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   always_comb begin
      starve_cnt_d = starve_next(starve_cnt_q, STARVE_LIM, p1.req, gnt0, gnt1);

      lock_state_d = lock_state_q;
      case (lock_state_q)
         UNLOCKED: if (gnt1 && lock1)        lock_state_d = LOCKED;
         LOCKED:   if (!lock1 || !p1.req)    lock_state_d = UNLOCKED;
         default:                            lock_state_d = UNLOCKED;
      endcase

      // the tag leaving the pipe marks the edge on which mem.q belongs to it
      rvalid0_d = tag_out.valid && (tag_out.owner == PORT_CPU);
      rvalid1_d = tag_out.valid && (tag_out.owner == PORT_AUX);
      rdata0_d  = rvalid0_d ? mem.q : rdata0_q;
      rdata1_d  = rvalid1_d ? mem.q : rdata1_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lock_state_q <= UNLOCKED;
         starve_cnt_q <= 4'd0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         lock_state_q <= lock_state_d;
         starve_cnt_q <= starve_cnt_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level model predicts grants, mem pins
// and read returns every cycle; directed scenarios add literal expectations.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int AW = DEF_ADDR_W;
   localparam int DW = DEF_DATA_W;
   localparam int RL = 1;
   localparam int SM = 4;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          lock;
   } txn_t;

   typedef struct {
      int            due;
      logic          owner;
      logic [DW-1:0] data;
   } ret_t;

   logic clock = 1'b0;
   logic rst_n = 1'b0;
   logic lock1;
   always #5 clock = ~clock;

   dmem_port_if #(.ADDR_W(AW), .DATA_W(DW)) p0 ();
   dmem_port_if #(.ADDR_W(AW), .DATA_W(DW)) p1 ();
   dmem_mem_if  #(.ADDR_W(AW), .DATA_W(DW)) mb ();

   dmem_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .READ_LAT   (RL),
      .STARVE_MAX (SM)
   ) dut (
      .clock (clock),
      .reset (rst_n),
      .p0    (p0),
      .p1    (p1),
      .lock1 (lock1),
      .mem   (mb)
   );

   // ---------------- dmem: synchronous RAM, q valid RL cycles after address
   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      if (a == 12'h010) return 32'hDEADBEEF;
      return 32'hA5A5_0000 | {20'h0, a};
   endfunction

   logic [DW-1:0] ram [1<<AW];
   logic [DW-1:0] q_pipe [RL];
   logic          ram_ready = 1'b0;

   always @(posedge clock) begin
      if (!ram_ready) begin
         for (int i = 0; i < (1 << AW); i++) ram[i] <= init_word(AW'(i));
         ram_ready <= 1'b1;
      end else if (mb.wren) begin
         ram[mb.addr] <= mb.data;
      end
      q_pipe[0] <= ram[mb.addr];
      for (int k = 1; k < RL; k++) q_pipe[k] <= q_pipe[k-1];
   end
   assign mb.q = q_pipe[RL-1];

   // ---------------- checking infrastructure
   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   txn_t          q0[$];
   txn_t          q1[$];
   ret_t          exp_q[$];
   logic [DW-1:0] mdl_mem [int];
   bit            log_en = 1'b0;
   int            gnt_log[$];
   int            gnt_cyc[$];
   int            ret_own[$];
   int            ret_cyc[$];
   logic [DW-1:0] ret_dat[$];
   int            cyc = 0;

   function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a);
      if (mdl_mem.exists(int'(a))) return mdl_mem[int'(a)];
      return init_word(a);
   endfunction

   task automatic clear_logs();
      gnt_log.delete(); gnt_cyc.delete();
      ret_own.delete(); ret_cyc.delete(); ret_dat.delete();
   endtask

   // ---------------- driver + model + per-cycle compare
   initial begin : monitor
      int            m_starve;
      bit            m_locked;
      int            g;
      logic          r0, r1, lk;
      logic          ev0, ev1;
      logic [DW-1:0] erd0, erd1;
      ret_t          e;
      txn_t          t0, t1, ts;

      m_starve = 0; m_locked = 1'b0; erd0 = '0; erd1 = '0;
      p0.req = 1'b0; p0.we = 1'b0; p0.addr = '0; p0.wdata = '0;
      p1.req = 1'b0; p1.we = 1'b0; p1.addr = '0; p1.wdata = '0;
      lock1  = 1'b0;
      forever begin
         @(negedge clock);
         cyc++;
         if (!rst_n) begin
            chk("rst_gnt0",    64'(p0.gnt),    64'd0);
            chk("rst_gnt1",    64'(p1.gnt),    64'd0);
            chk("rst_rvalid0", 64'(p0.rvalid), 64'd0);
            chk("rst_rvalid1", 64'(p1.rvalid), 64'd0);
            chk("rst_rdata0",  64'(p0.rdata),  64'd0);
            chk("rst_rdata1",  64'(p1.rdata),  64'd0);
            chk("rst_wren",    64'(mb.wren),   64'd0);
            m_starve = 0; m_locked = 1'b0; erd0 = '0; erd1 = '0;
            exp_q.delete();
            p0.req = 1'b0; p1.req = 1'b0; lock1 = 1'b0;
         end else begin
            ev0 = 1'b0; ev1 = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
               e = exp_q.pop_front();
               if (e.owner) begin ev1 = 1'b1; erd1 = e.data; end
               else         begin ev0 = 1'b1; erd0 = e.data; end
            end
            chk("rvalid0", 64'(p0.rvalid), 64'(ev0));
            chk("rvalid1", 64'(p1.rvalid), 64'(ev1));
            chk("rdata0",  64'(p0.rdata),  64'(erd0));
            chk("rdata1",  64'(p1.rdata),  64'(erd1));
            if (log_en && (p0.rvalid || p1.rvalid)) begin
               ret_own.push_back(p1.rvalid ? 1 : 0);
               ret_dat.push_back(p1.rvalid ? p1.rdata : p0.rdata);
               ret_cyc.push_back(cyc);
            end

            r0 = (q0.size() > 0);
            r1 = (q1.size() > 0);
            t0 = '{we: 1'b0, addr: '0, wdata: '0, lock: 1'b0};
            t1 = t0;
            if (r0) t0 = q0[0];
            if (r1) t1 = q1[0];
            lk = r1 && t1.lock;
            p0.req = r0; p0.we = t0.we; p0.addr = t0.addr; p0.wdata = t0.wdata;
            p1.req = r1; p1.we = t1.we; p1.addr = t1.addr; p1.wdata = t1.wdata;
            lock1  = lk;
            #1;

            g = 2;
            if (m_locked && r1)            g = 1;
            else if (r1 && m_starve == SM) g = 1;
            else if (r0)                   g = 0;
            else if (r1)                   g = 1;

            chk("gnt0", 64'(p0.gnt), 64'(g == 0));
            chk("gnt1", 64'(p1.gnt), 64'(g == 1));
            chk("mem_wren", 64'(mb.wren), 64'((g == 0) ? t0.we : (g == 1) ? t1.we : 1'b0));
            chk("mem_addr", 64'(mb.addr), 64'((g == 1) ? t1.addr : t0.addr));
            chk("mem_data", 64'(mb.data), 64'((g == 1) ? t1.wdata : t0.wdata));
            if (log_en && (p0.gnt || p1.gnt)) begin
               gnt_log.push_back(p1.gnt ? 1 : 0);
               gnt_cyc.push_back(cyc);
            end

            if (g != 2) begin
               ts = (g == 1) ? t1 : t0;
               if (ts.we) mdl_mem[int'(ts.addr)] = ts.wdata;
               else exp_q.push_back('{due: cyc + RL + 1, owner: (g == 1), data: mdl_read(ts.addr)});
            end
            if (!r1 || g == 1)               m_starve = 0;
            else if (g == 0 && m_starve < SM) m_starve++;
            if (!m_locked)         m_locked = (g == 1) && lk;
            else if (!lk || !r1)   m_locked = 1'b0;
            if (g == 0) void'(q0.pop_front());
            if (g == 1) void'(q1.pop_front());
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < 60) begin
         @(posedge clock);
         n++;
      end
      repeat (2) @(posedge clock);
      chk("idle_timeout", 64'(q0.size() + q1.size() + exp_q.size()), 64'd0);
   endtask

   function automatic txn_t rd(input logic [AW-1:0] a);
      return '{we: 1'b0, addr: a, wdata: 32'h1234_0000 | {20'h0, a}, lock: 1'b0};
   endfunction

   // ---------------- directed scenarios
   initial begin : main
      int exp2 [10];
      int exp3 [8];
      exp2 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      exp3 = '{0, 0, 0, 0, 1, 1, 1, 0};

      repeat (4) @(posedge clock);
      #2 rst_n = 1'b1;
      log_en = 1'b1;

      // single CPU read of preloaded word
      clear_logs();
      q0.push_back(rd(12'h010));
      wait_idle();
      chk("t1_ngnt",    64'(gnt_log.size()), 64'd1);
      chk("t1_owner",   64'(gnt_log[0]),     64'd0);
      chk("t1_nret",    64'(ret_own.size()), 64'd1);
      chk("t1_rport",   64'(ret_own[0]),     64'd0);
      chk("t1_rdata",   64'(ret_dat[0]),     64'hDEADBEEF);
      chk("t1_latency", 64'(ret_cyc[0] - gnt_cyc[0]), 64'd2);

      // both ports saturated: starvation counter forces every fifth grant to AUX
      clear_logs();
      for (int i = 0; i < 8; i++) q0.push_back(rd(AW'(12'h050 + i)));
      for (int i = 0; i < 2; i++) q1.push_back(rd(AW'(12'h060 + i)));
      wait_idle();
      chk("t2_ngnt", 64'(gnt_log.size()), 64'd10);
      for (int i = 0; i < 10; i++) chk($sformatf("t2_gnt%0d", i), 64'(gnt_log[i]), 64'(exp2[i]));

      // AUX burst of three locked writes while CPU keeps requesting
      clear_logs();
      for (int i = 0; i < 5; i++) q0.push_back(rd(AW'(12'h200 + i)));
      for (int i = 0; i < 3; i++)
         q1.push_back('{we: 1'b1, addr: AW'(12'h100 + i), wdata: DW'(i + 1), lock: 1'b1});
      wait_idle();
      for (int i = 0; i < 8; i++) chk($sformatf("t3_gnt%0d", i), 64'(gnt_log[i]), 64'(exp3[i]));
      clear_logs();
      for (int i = 0; i < 3; i++) q0.push_back(rd(AW'(12'h100 + i)));
      wait_idle();
      chk("t3_nret", 64'(ret_dat.size()), 64'd3);
      for (int i = 0; i < 3; i++) chk($sformatf("t3_rd%0d", i), 64'(ret_dat[i]), 64'(i + 1));

      // alternating owners on consecutive grants
      clear_logs();
      @(posedge clock);
      q0.push_back(rd(12'h020));
      q1.push_back(rd(12'h021));
      repeat (2) @(posedge clock);
      q0.push_back(rd(12'h022));
      wait_idle();
      chk("t4_nret",  64'(ret_own.size()), 64'd3);
      chk("t4_own0",  64'(ret_own[0]), 64'd0);
      chk("t4_own1",  64'(ret_own[1]), 64'd1);
      chk("t4_own2",  64'(ret_own[2]), 64'd0);
      chk("t4_dat0",  64'(ret_dat[0]), 64'hA5A50020);
      chk("t4_dat1",  64'(ret_dat[1]), 64'hA5A50021);
      chk("t4_dat2",  64'(ret_dat[2]), 64'hA5A50022);
      chk("t4_gap01", 64'(ret_cyc[1] - ret_cyc[0]), 64'd1);
      chk("t4_gap12", 64'(ret_cyc[2] - ret_cyc[1]), 64'd1);

      // write then immediate read of the same word
      clear_logs();
      q0.push_back('{we: 1'b1, addr: 12'h030, wdata: 32'h5A5A5A5A, lock: 1'b0});
      q0.push_back(rd(12'h030));
      wait_idle();
      chk("t5_ngnt",  64'(gnt_log.size()), 64'd2);
      chk("t5_nret",  64'(ret_own.size()), 64'd1);
      chk("t5_rport", 64'(ret_own[0]),     64'd0);
      chk("t5_rdata", 64'(ret_dat[0]),     64'h5A5A5A5A);

      // reset arrives while a read is in flight
      clear_logs();
      q0.push_back(rd(12'h040));
      for (int i = 0; i < 10 && q0.size() > 0; i++) @(posedge clock);
      chk("t6_granted", 64'(q0.size()), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rvalid0", 64'(p0.rvalid), 64'd0);
      chk("t6_rdata0",  64'(p0.rdata),  64'd0);
      chk("t6_wren",    64'(mb.wren),   64'd0);
      repeat (2) @(posedge clock);
      #2 rst_n = 1'b1;
      repeat (6) @(posedge clock);
      chk("t6_nret", 64'(ret_own.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port dmem between two requesters: port 0 is the processor load/store path and port 1 is a secondary master such as a display or DMA engine.
- Sits between the requesters and the dmem address/data/wren/q pins, and arbitrates one access per cycle.
- Port 0 has fixed priority. A starvation counter guarantees port 1 forward progress.
- Read data is returned to the owning port through a latency-matched tag pipeline.

Parameters:
- ADDR_W, 12, dmem word-address width
- DATA_W, 32, data width
- READ_LAT, 1, cycles from address presented to q valid (1 for the inverted-clock syncram)
- STARVE_MAX, 4, consecutive port-0 grants allowed while port 1 waits (range 1..15)

Ports:
- clock  in  1  master clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- req0  in  1  port 0 access request
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- gnt0  out  1  port 0 granted this cycle
- rvalid0  out  1  port 0 read data valid
- rdata0  out  DATA_W  port 0 read data
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same meanings and widths for port 1
- lock1  in  1  port 1 burst lock; holds the grant on port 1 while asserted with req1
- mem_addr  out  ADDR_W  to dmem address
- mem_data  out  DATA_W  to dmem data
- mem_wren  out  1  to dmem wren
- mem_q  in  DATA_W  from dmem q

Behaviour:
- Reset (reset=0, asynchronous):
  - starve_cnt=0, lock_state=UNLOCKED, tag pipeline cleared.
  - rvalid0=rvalid1=0, gnt0=gnt1=0, mem_wren=0.
  - rdata0 and rdata1 are 0.
- Grant is combinational from the inputs and registered state, with at most one grant per cycle.
  - A requester must hold req and its fields stable until it sees gnt high in the same cycle.
- Grant priority, first match wins:
  1. lock_state=LOCKED and req1 -> gnt1.
  2. req1 and starve_cnt==STARVE_MAX -> gnt1.
  3. req0 -> gnt0.
  4. req1 -> gnt1.
  5. Otherwise no grant.
- Memory drive: mem_addr and mem_data are taken from the granted port. With no grant, they hold port 0's values.
  - mem_wren = granted port's we, and 0 if there is no grant.
- starve_cnt (4-bit, registered):
  - Increments when gnt0 && req1.
  - Clears on gnt1, or when req1=0.
  - Saturates at STARVE_MAX.
- Lock FSM, two states:
  - UNLOCKED -> LOCKED on gnt1 && lock1.
  - LOCKED -> UNLOCKED when !lock1 || !req1.
  - While LOCKED, port 0 is never granted. The lock does not assert gnt1 without req1.
- Read return:
  - A granted read (we=0) pushes a {valid, owner} tag into a READ_LAT-deep shift register. Writes push valid=0.
  - When a tag exits the pipeline, rvalid[owner]=1 for one cycle and rdata[owner]=mem_q registered on that edge.
  - The other port's rvalid is 0 that cycle. rdata holds its value when rvalid=0.
- Back-to-back reads from alternating ports return in grant order, one per cycle, with no bubbles.
- Writes produce no rvalid. A write followed by a read of the same address returns the new data (single port, ordered).
- Reset mid-read: the tag is discarded and no rvalid is produced after reset deasserts.
- Simultaneous req0 and req1 with starve_cnt<STARVE_MAX: port 0 wins and the counter increments.

Decomposition:
- Shared package holds:
  - Port-id constants PORT_CPU=0 and PORT_AUX=1.
  - Lock-state encoding UNLOCKED=0 and LOCKED=1.
  - Default width constants (12 and 32).
- One sub-module: dmem_rtag_pipe, the READ_LAT-deep {valid, owner} shift register with async active-low clear.

Test Plan:
1. Only req0 reads addr 0x010, with dmem preloaded to 0xDEADBEEF -> gnt0=1 in the same cycle; rvalid0=1 and rdata0=0xDEADBEEF after READ_LAT cycles; rvalid1 stays 0.
2. req0 and req1 held high continuously with STARVE_MAX=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1; starve_cnt reads 0 after each gnt1.
3. Port 1 asserts lock1 and issues 3 writes to addr 0x100..0x102 (values 1,2,3) while req0 is held high -> gnt1 for 3 consecutive cycles and gnt0=0; after lock1 drops, gnt0 the next cycle; port-0 reads of 0x100..0x102 then return 1,2,3.
4. Alternating reads: port 0 reads 0x020, port 1 reads 0x021, port 0 reads 0x022 on consecutive grants -> rvalid sequence 0,1,0 on consecutive cycles, each carrying its own address's data.
5. Port 0 writes 0x5A5A5A5A to 0x030, then immediately reads 0x030 -> rdata0=0x5A5A5A5A and no rvalid for the write.
6. Reset pulled low one cycle after a granted read -> no rvalid on either port after release; all outputs 0 during reset.
